cu_id_queue: RTL and testbench

//  Parametrised decode stage for the CU: accepts fetched RV32I words over a valid/ready

---
 rtl/idu_pkg.sv | 71 +++++++
 rtl/cu_id_queue_chk.sv | 32 +++
 rtl/idu_decode_comb.sv | 144 ++++++++++++++
 rtl/cu_id_queue.sv | 128 ++++++++++++
 tb/tb_cu_id_queue.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/idu_pkg.sv
// Shared types for the CU decode queue: instruction classes, ALU ops, RV32I opcodes
// and the decoded bundle that is stored per queue entry.
package idu_pkg;

    localparam int XLEN_C = 32;

    typedef enum logic [5:0] {
        INVALID = 6'd0,
        ALU_REG = 6'd1,
        ALU_IMM = 6'd2,
        LOAD    = 6'd3,
        STORE   = 6'd4,
        BRANCH  = 6'd5,
        JAL     = 6'd6,
        JALR    = 6'd7,
        LUI     = 6'd8,
        AUIPC   = 6'd9,
        FENCE   = 6'd10,
        SYSTEM  = 6'd11
    } inst_class_e;

    typedef enum logic [4:0] {
        ALU_NOP   = 5'd0,
        ALU_ADD   = 5'd1,
        ALU_SUB   = 5'd2,
        ALU_SLL   = 5'd3,
        ALU_SLT   = 5'd4,
        ALU_SLTU  = 5'd5,
        ALU_XOR   = 5'd6,
        ALU_SRL   = 5'd7,
        ALU_SRA   = 5'd8,
        ALU_OR    = 5'd9,
        ALU_AND   = 5'd10,
        ALU_PASSB = 5'd11,
        ALU_BEQ   = 5'd12,
        ALU_BNE   = 5'd13,
        ALU_BLT   = 5'd14,
        ALU_BGE   = 5'd15,
        ALU_BLTU  = 5'd16,
        ALU_BGEU  = 5'd17
    } alu_op_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        inst_class_e        cls;
        alu_op_e            alu_op;
        logic [XLEN_C-1:0]  imm;
        logic [4:0]         rd;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [4:0]         shamt;
        logic [XLEN_C-1:0]  pc;
        logic               invalid;
    } decoded_t;

    function automatic logic [XLEN_C-1:0] sext12(input logic [11:0] v);
        return {{(XLEN_C-12){v[11]}}, v};
    endfunction

endpackage

// File: rtl/cu_id_queue_chk.sv
// Handshake protocol checks for the decode queue: producers hold payload while stalled,
// and the head entry stays put while the CU has not taken it.
module cu_id_queue_chk #(
    parameter int XLEN = 32
)(
    input logic            soc_clk,
    input logic            reset,
    input logic            fetch_valid,
    input logic            fetch_ready,
    input logic            flush,
    input logic            issue_valid,
    input logic            issue_ready,
    input logic [XLEN-1:0] instr,
    input logic [XLEN-1:0] instr_pc,
    input logic [XLEN-1:0] issue_pc
);

    property p_fetch_hold;
        @(posedge soc_clk) disable iff (!reset)
            (fetch_valid && !fetch_ready && !flush) |=>
                (fetch_valid && $stable(instr) && $stable(instr_pc));
    endproperty

    property p_head_hold;
        @(posedge soc_clk) disable iff (!reset)
            (issue_valid && !issue_ready && !flush) |=> $stable(issue_pc);
    endproperty

    a_fetch_hold: assert property (p_fetch_hold);
    a_head_hold:  assert property (p_head_hold);

endmodule

// File: rtl/idu_decode_comb.sv
// Purely combinational RV32I decoder: raw word + PC -> decoded_t bundle.
// Fields a format does not use are driven to zero; failed decodes keep only the PC.
module idu_decode_comb
    import idu_pkg::*;
(
    input  logic [XLEN_C-1:0] i_instr,
    input  logic [XLEN_C-1:0] i_pc,
    output decoded_t          o_dec
);

    logic [6:0]        w_opcode;
    logic [2:0]        w_funct3;
    logic [6:0]        w_funct7;
    logic [4:0]        w_rd;
    logic [4:0]        w_rs1;
    logic [4:0]        w_rs2;
    logic [XLEN_C-1:0] w_imm_i;
    logic [XLEN_C-1:0] w_imm_s;
    logic [XLEN_C-1:0] w_imm_b;
    logic [XLEN_C-1:0] w_imm_u;
    logic [XLEN_C-1:0] w_imm_j;
    decoded_t          w_dec;
    logic              w_bad;

    assign w_opcode = i_instr[6:0];
    assign w_funct3 = i_instr[14:12];
    assign w_funct7 = i_instr[31:25];
    assign w_rd     = i_instr[11:7];
    assign w_rs1    = i_instr[19:15];
    assign w_rs2    = i_instr[24:20];
    assign w_imm_i  = sext12(i_instr[31:20]);
    assign w_imm_s  = sext12({i_instr[31:25], i_instr[11:7]});
    assign w_imm_b  = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
    assign w_imm_u  = {i_instr[31:12], 12'h000};
    assign w_imm_j  = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

    // Opcode/funct decode into class, ALU op, operands and immediate
    always_comb begin
        w_dec        = '0;
        w_dec.cls    = INVALID;
        w_dec.alu_op = ALU_NOP;
        w_bad        = 1'b0;
        case (w_opcode)
            OPC_LUI: begin
                w_dec.cls = LUI;  w_dec.alu_op = ALU_PASSB; w_dec.imm = w_imm_u; w_dec.rd = w_rd;
            end
            OPC_AUIPC: begin
                w_dec.cls = AUIPC; w_dec.alu_op = ALU_ADD; w_dec.imm = w_imm_u; w_dec.rd = w_rd;
            end
            OPC_JAL: begin
                w_dec.cls = JAL;  w_dec.alu_op = ALU_ADD; w_dec.imm = w_imm_j; w_dec.rd = w_rd;
            end
            OPC_JALR: begin
                w_dec.cls = JALR; w_dec.alu_op = ALU_ADD; w_dec.imm = w_imm_i;
                w_dec.rd  = w_rd; w_dec.rs1 = w_rs1;
                w_bad     = (w_funct3 != 3'd0);
            end
            OPC_BRANCH: begin
                w_dec.cls = BRANCH; w_dec.imm = w_imm_b; w_dec.rs1 = w_rs1; w_dec.rs2 = w_rs2;
                case (w_funct3)
                    3'd0:    w_dec.alu_op = ALU_BEQ;
                    3'd1:    w_dec.alu_op = ALU_BNE;
                    3'd4:    w_dec.alu_op = ALU_BLT;
                    3'd5:    w_dec.alu_op = ALU_BGE;
                    3'd6:    w_dec.alu_op = ALU_BLTU;
                    3'd7:    w_dec.alu_op = ALU_BGEU;
                    default: w_bad = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                w_dec.cls = LOAD; w_dec.alu_op = ALU_ADD; w_dec.imm = w_imm_i;
                w_dec.rd  = w_rd; w_dec.rs1 = w_rs1;
                w_bad     = (w_funct3 == 3'd3) || (w_funct3 == 3'd6) || (w_funct3 == 3'd7);
            end
            OPC_STORE: begin
                w_dec.cls = STORE; w_dec.alu_op = ALU_ADD; w_dec.imm = w_imm_s;
                w_dec.rs1 = w_rs1; w_dec.rs2 = w_rs2;
                w_bad     = (w_funct3 > 3'd2);
            end
            OPC_OPIMM: begin
                w_dec.cls = ALU_IMM; w_dec.imm = w_imm_i; w_dec.rd = w_rd; w_dec.rs1 = w_rs1;
                case (w_funct3)
                    3'd0: w_dec.alu_op = ALU_ADD;
                    3'd2: w_dec.alu_op = ALU_SLT;
                    3'd3: w_dec.alu_op = ALU_SLTU;
                    3'd4: w_dec.alu_op = ALU_XOR;
                    3'd6: w_dec.alu_op = ALU_OR;
                    3'd7: w_dec.alu_op = ALU_AND;
                    3'd1: begin
                        w_dec.alu_op = ALU_SLL;
                        w_dec.shamt  = w_rs2;
                        w_bad        = (w_funct7 != 7'h00);
                    end
                    3'd5: begin
                        w_dec.alu_op = (w_funct7 == 7'h20) ? ALU_SRA : ALU_SRL;
                        w_dec.shamt  = w_rs2;
                        w_bad        = (w_funct7 != 7'h00) && (w_funct7 != 7'h20);
                    end
                    default: w_bad = 1'b1;
                endcase
            end
            OPC_OP: begin
                w_dec.cls = ALU_REG; w_dec.rd = w_rd; w_dec.rs1 = w_rs1; w_dec.rs2 = w_rs2;
                case ({w_funct7, w_funct3})
                    {7'h00, 3'd0}: w_dec.alu_op = ALU_ADD;
                    {7'h20, 3'd0}: w_dec.alu_op = ALU_SUB;
                    {7'h00, 3'd1}: w_dec.alu_op = ALU_SLL;
                    {7'h00, 3'd2}: w_dec.alu_op = ALU_SLT;
                    {7'h00, 3'd3}: w_dec.alu_op = ALU_SLTU;
                    {7'h00, 3'd4}: w_dec.alu_op = ALU_XOR;
                    {7'h00, 3'd5}: w_dec.alu_op = ALU_SRL;
                    {7'h20, 3'd5}: w_dec.alu_op = ALU_SRA;
                    {7'h00, 3'd6}: w_dec.alu_op = ALU_OR;
                    {7'h00, 3'd7}: w_dec.alu_op = ALU_AND;
                    default:       w_bad = 1'b1;
                endcase
            end
            OPC_FENCE: begin
                w_dec.cls = FENCE;
                w_bad     = (w_funct3 != 3'd0);
            end
            OPC_SYSTEM: begin
                w_dec.cls = SYSTEM;
                w_bad     = (i_instr != 32'h0000_0073) && (i_instr != 32'h0010_0073);
            end
            default: w_bad = 1'b1;
        endcase
    end

    // Failed decodes collapse to a clean INVALID bundle so the CU can trap on it
    always_comb begin
        if (w_bad) begin
            o_dec         = '0;
            o_dec.cls     = INVALID;
            o_dec.alu_op  = ALU_NOP;
            o_dec.pc      = i_pc;
            o_dec.invalid = 1'b1;
        end else begin
            o_dec    = w_dec;
            o_dec.pc = i_pc;
        end
    end

endmodule

// File: rtl/cu_id_queue.sv
// Decode stage queue: decodes fetched words on entry and buffers the bundles in a
// DEPTH-entry FIFO with valid/ready on both sides, flush on redirect and occupancy output.
module cu_id_queue
    import idu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
)(
    input  logic                   soc_clk,
    input  logic                   reset,
    input  logic                   fetch_valid,
    output logic                   fetch_ready,
    input  logic [XLEN-1:0]        instr,
    input  logic [XLEN-1:0]        instr_pc,
    input  logic                   flush,
    input  logic                   IDU_stall,
    output logic                   issue_valid,
    input  logic                   issue_ready,
    output logic [5:0]             Instruction_to_CU,
    output logic [4:0]             Instruction_to_ALU,
    output logic [XLEN-1:0]        imm,
    output logic [4:0]             rd,
    output logic [4:0]             rs1,
    output logic [4:0]             rs2,
    output logic [4:0]             shamt,
    output logic [XLEN-1:0]        issue_pc,
    output logic [XLEN-1:0]        pc_increment,
    output logic                   invalid_instruction,
    output logic [$clog2(DEPTH):0] occupancy
);

    // DEPTH must be a power of two so the pointers wrap for free; XLEN is fixed at 32
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    decoded_t           r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    decoded_t           w_dec;
    decoded_t           w_head;
    logic               w_nonempty;
    logic               w_not_full;
    logic               w_push;
    logic               w_pop;

    idu_decode_comb u_decode (
        .i_instr (instr),
        .i_pc    (instr_pc),
        .o_dec   (w_dec)
    );

    assign w_nonempty  = (r_count != CNT_W'(0));
    assign w_not_full  = (r_count < CNT_W'(DEPTH));
    assign issue_valid = w_nonempty & ~IDU_stall & ~flush;
    assign w_pop       = issue_valid & issue_ready;
    // Gating with reset keeps fetch stalled while the queue is held in reset
    assign fetch_ready = reset & ~flush & (w_not_full | w_pop);
    assign w_push      = fetch_valid & fetch_ready;

    // Pointer and occupancy bookkeeping; flush empties the queue at the next edge
    always_ff @(posedge soc_clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage, written only on an accepted push
    always_ff @(posedge soc_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_dec;
        end
    end

    // Head selection; an empty queue presents zeros rather than stale storage
    always_comb begin
        if (w_nonempty) begin
            w_head = r_mem[r_rd_ptr];
        end else begin
            w_head = '0;
        end
    end

    assign Instruction_to_CU   = w_head.cls;
    assign Instruction_to_ALU  = w_head.alu_op;
    assign imm                 = w_head.imm;
    assign rd                  = w_head.rd;
    assign rs1                 = w_head.rs1;
    assign rs2                 = w_head.rs2;
    assign shamt               = w_head.shamt;
    assign issue_pc            = w_head.pc;
    assign invalid_instruction = w_head.invalid;
    assign pc_increment        = XLEN'(4);
    assign occupancy           = r_count;

    cu_id_queue_chk #(.XLEN(XLEN)) u_chk (
        .soc_clk     (soc_clk),
        .reset       (reset),
        .fetch_valid (fetch_valid),
        .fetch_ready (fetch_ready),
        .flush       (flush),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .issue_pc    (issue_pc)
    );

endmodule

// File: tb/tb_cu_id_queue.sv
// Self-checking bench for cu_id_queue: decode vector table plus a scoreboard queue model
// checked every falling edge, and hand-written flush/stall/reset/backpressure sequences.
`timescale 1ns/1ps
module tb_cu_id_queue;
    import idu_pkg::*;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [5:0]  cls;
        logic [4:0]  alu;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  shamt;
        logic [31:0] pc;
        logic        inv;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        exp_t        e;
    } vec_t;

    logic        soc_clk;
    logic        reset;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        flush;
    logic        IDU_stall;
    logic        issue_valid;
    logic        issue_ready;
    logic [5:0]  Instruction_to_CU;
    logic [4:0]  Instruction_to_ALU;
    logic [31:0] imm;
    logic [4:0]  rd, rs1, rs2, shamt;
    logic [31:0] issue_pc;
    logic [31:0] pc_increment;
    logic        invalid_instruction;
    logic [2:0]  occupancy;

    int   total = 0;
    int   bad   = 0;
    vec_t tab [16];
    exp_t sb [$];
    exp_t cur_exp;
    logic pend_push, pend_pop, pend_flush;
    exp_t pend_word;

    cu_id_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
        .soc_clk             (soc_clk),
        .reset               (reset),
        .fetch_valid         (fetch_valid),
        .fetch_ready         (fetch_ready),
        .instr               (instr),
        .instr_pc            (instr_pc),
        .flush               (flush),
        .IDU_stall           (IDU_stall),
        .issue_valid         (issue_valid),
        .issue_ready         (issue_ready),
        .Instruction_to_CU   (Instruction_to_CU),
        .Instruction_to_ALU  (Instruction_to_ALU),
        .imm                 (imm),
        .rd                  (rd),
        .rs1                 (rs1),
        .rs2                 (rs2),
        .shamt               (shamt),
        .issue_pc            (issue_pc),
        .pc_increment        (pc_increment),
        .invalid_instruction (invalid_instruction),
        .occupancy           (occupancy)
    );

    initial soc_clk = 1'b0;
    always #5 soc_clk = ~soc_clk;

    function automatic vec_t mkv(input logic [31:0] w, input logic [5:0] c, input logic [4:0] a,
                                 input logic [31:0] im, input logic [4:0] d, input logic [4:0] s1,
                                 input logic [4:0] s2, input logic [4:0] sh, input logic iv);
        vec_t v;
        v.instr = w;
        v.e     = '{c, a, im, d, s1, s2, sh, 32'h0, iv};
        return v;
    endfunction

    task automatic chk(input string nm, input logic [95:0] got, input logic [95:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    task automatic tick();
        @(posedge soc_clk);
        #1;
    endtask

    // Present a word and hold it until accepted, bounded by a cycle budget
    task automatic push(input int idx, input logic [31:0] pc);
        bit done;
        done        = 1'b0;
        fetch_valid = 1'b1;
        instr       = tab[idx].instr;
        instr_pc    = pc;
        cur_exp     = tab[idx].e;
        cur_exp.pc  = pc;
        for (int n = 0; n < 24 && !done; n++) begin
            #1;
            done = fetch_ready;
            tick();
        end
        fetch_valid = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL push_timeout idx=%0d got fetch_ready=0 want 1", idx);
        end
    endtask

    // Scoreboard monitor: compare handshake, occupancy and head against the model
    always @(negedge soc_clk) begin : mon
        exp_t h;
        logic e_iv, e_pop, e_fr;
        e_iv  = reset && (sb.size() != 0) && !IDU_stall && !flush;
        e_pop = e_iv && issue_ready;
        e_fr  = reset && !flush && ((sb.size() < DEPTH) || e_pop);
        if (sb.size() != 0) h = sb[0];
        else                h = '0;
        chk("fetch_ready", {95'd0, fetch_ready}, {95'd0, e_fr});
        chk("issue_valid", {95'd0, issue_valid}, {95'd0, e_iv});
        chk("occupancy",   {93'd0, occupancy}, 96'(sb.size()));
        chk("head", {Instruction_to_CU, Instruction_to_ALU, imm, rd, rs1, rs2, shamt,
                     issue_pc, invalid_instruction}, h);
        chk("pc_increment", {64'd0, pc_increment}, 96'd4);
        pend_push  = fetch_valid && e_fr;
        pend_pop   = e_pop;
        pend_flush = reset && flush;
        pend_word  = cur_exp;
    end

    // Model state update on the clock, cleared immediately by reset
    always @(posedge soc_clk or negedge reset) begin
        if (!reset) begin
            sb.delete();
        end else if (pend_flush) begin
            sb.delete();
        end else begin
            if (pend_pop && sb.size() != 0) void'(sb.pop_front());
            if (pend_push) sb.push_back(pend_word);
        end
    end

    initial begin
        tab[0]  = mkv(32'h00500093, ALU_IMM, ALU_ADD,   32'd5,          5'd1,  5'd0, 5'd0,  5'd0,  1'b0);
        tab[1]  = mkv(32'h002081B3, ALU_REG, ALU_ADD,   32'd0,          5'd3,  5'd1, 5'd2,  5'd0,  1'b0);
        tab[2]  = mkv(32'h407302B3, ALU_REG, ALU_SUB,   32'd0,          5'd5,  5'd6, 5'd7,  5'd0,  1'b0);
        tab[3]  = mkv(32'h40325213, ALU_IMM, ALU_SRA,   32'h00000403,   5'd4,  5'd4, 5'd0,  5'd3,  1'b0);
        tab[4]  = mkv(32'hFFC12503, LOAD,    ALU_ADD,   32'hFFFFFFFC,   5'd10, 5'd2, 5'd0,  5'd0,  1'b0);
        tab[5]  = mkv(32'h00B12423, STORE,   ALU_ADD,   32'd8,          5'd0,  5'd2, 5'd11, 5'd0,  1'b0);
        tab[6]  = mkv(32'hFE208CE3, BRANCH,  ALU_BEQ,   32'hFFFFFFF8,   5'd0,  5'd1, 5'd2,  5'd0,  1'b0);
        tab[7]  = mkv(32'h123453B7, LUI,     ALU_PASSB, 32'h12345000,   5'd7,  5'd0, 5'd0,  5'd0,  1'b0);
        tab[8]  = mkv(32'h001000EF, JAL,     ALU_ADD,   32'h00000800,   5'd1,  5'd0, 5'd0,  5'd0,  1'b0);
        tab[9]  = mkv(32'h00008067, JALR,    ALU_ADD,   32'd0,          5'd0,  5'd1, 5'd0,  5'd0,  1'b0);
        tab[10] = mkv(32'hFFFFF117, AUIPC,   ALU_ADD,   32'hFFFFF000,   5'd2,  5'd0, 5'd0,  5'd0,  1'b0);
        tab[11] = mkv(32'h01F09093, ALU_IMM, ALU_SLL,   32'h0000001F,   5'd1,  5'd1, 5'd0,  5'd31, 1'b0);
        tab[12] = mkv(32'hFFFFFFFF, INVALID, ALU_NOP,   32'd0,          5'd0,  5'd0, 5'd0,  5'd0,  1'b1);
        tab[13] = mkv(32'h022081B3, INVALID, ALU_NOP,   32'd0,          5'd0,  5'd0, 5'd0,  5'd0,  1'b1);
        tab[14] = mkv(32'h41F09093, INVALID, ALU_NOP,   32'd0,          5'd0,  5'd0, 5'd0,  5'd0,  1'b1);
        tab[15] = mkv(32'h00000073, SYSTEM,  ALU_NOP,   32'd0,          5'd0,  5'd0, 5'd0,  5'd0,  1'b0);

        reset = 1'b0; fetch_valid = 1'b0; instr = 32'd0; instr_pc = 32'd0;
        flush = 1'b0; IDU_stall = 1'b0; issue_ready = 1'b0; cur_exp = '0;
        repeat (3) tick();
        chk("rst_fetch_ready", {95'd0, fetch_ready}, 96'd0);
        reset = 1'b1;
        #1;
        chk("rel_fetch_ready", {95'd0, fetch_ready}, 96'd1);

        // single ADDI through an empty queue
        issue_ready = 1'b1;
        push(0, 32'h100);
        chk("addi_valid", {95'd0, issue_valid}, 96'd1);
        chk("addi_pc",    {64'd0, issue_pc}, 96'h100);
        chk("addi_imm",   {64'd0, imm}, 96'd5);
        chk("addi_rd",    {91'd0, rd}, 96'd1);
        chk("addi_cls",   {90'd0, Instruction_to_CU}, 96'(ALU_IMM));
        chk("addi_occ",   {93'd0, occupancy}, 96'd1);
        tick();
        chk("addi_drain", {93'd0, occupancy}, 96'd0);

        // decode table, one word at a time
        for (int i = 0; i < 16; i++) begin
            exp_t w;
            w    = tab[i].e;
            w.pc = 32'h200 + 32'(4 * i);
            push(i, w.pc);
            chk($sformatf("vec%0d", i), {Instruction_to_CU, Instruction_to_ALU, imm, rd, rs1, rs2,
                                         shamt, issue_pc, invalid_instruction}, w);
        end
        tick();

        // backpressure: fill, hold a fifth word, then drain in order
        issue_ready = 1'b0;
        for (int k = 0; k < 4; k++) push(k, 32'h400 + 32'(4 * k));
        fetch_valid = 1'b1; instr = tab[4].instr; instr_pc = 32'h410;
        cur_exp = tab[4].e; cur_exp.pc = 32'h410;
        #1;
        chk("full_ready", {95'd0, fetch_ready}, 96'd0);
        chk("full_occ",   {93'd0, occupancy}, 96'd4);
        tick(); tick();
        chk("full_hold", {95'd0, fetch_ready}, 96'd0);
        issue_ready = 1'b1;
        push(4, 32'h410);
        repeat (8) tick();
        chk("drain_occ", {93'd0, occupancy}, 96'd0);

        // full queue with simultaneous push and pop
        issue_ready = 1'b0;
        for (int k = 0; k < 4; k++) push(k, 32'h500 + 32'(4 * k));
        issue_ready = 1'b1;
        for (int j = 0; j < 16; j++) push(j, 32'h600 + 32'(4 * j));
        chk("pp_occ", {93'd0, occupancy}, 96'd4);
        repeat (6) tick();
        chk("pp_drain", {93'd0, occupancy}, 96'd0);

        // flush with a word on the fetch side
        issue_ready = 1'b0;
        for (int k = 0; k < 3; k++) push(k + 5, 32'h700 + 32'(4 * k));
        fetch_valid = 1'b1; instr = tab[1].instr; instr_pc = 32'h7F0;
        cur_exp = tab[1].e; cur_exp.pc = 32'h7F0;
        flush = 1'b1;
        #1;
        chk("flush_ready", {95'd0, fetch_ready}, 96'd0);
        tick();
        flush = 1'b0; fetch_valid = 1'b0;
        chk("flush_occ",   {93'd0, occupancy}, 96'd0);
        chk("flush_valid", {95'd0, issue_valid}, 96'd0);
        issue_ready = 1'b1;
        tick();

        // invalid word under stall
        IDU_stall = 1'b1;
        push(12, 32'h800);
        chk("inv_flag",  {95'd0, invalid_instruction}, 96'd1);
        chk("inv_alu",   {91'd0, Instruction_to_ALU}, 96'(ALU_NOP));
        chk("inv_imm",   {64'd0, imm}, 96'd0);
        for (int k = 0; k < 3; k++) begin
            chk("stall_valid", {95'd0, issue_valid}, 96'd0);
            chk("stall_occ",   {93'd0, occupancy}, 96'd1);
            tick();
        end
        IDU_stall = 1'b0;
        #1;
        chk("unstall_valid", {95'd0, issue_valid}, 96'd1);
        tick();
        chk("unstall_occ", {93'd0, occupancy}, 96'd0);

        // reset asserted mid-stream
        issue_ready = 1'b0;
        push(0, 32'h900);
        push(1, 32'h904);
        chk("pre_rst_occ", {93'd0, occupancy}, 96'd2);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_occ",   {93'd0, occupancy}, 96'd0);
        chk("arst_valid", {95'd0, issue_valid}, 96'd0);
        chk("arst_ready", {95'd0, fetch_ready}, 96'd0);
        tick(); tick();
        reset = 1'b1;
        issue_ready = 1'b1;
        push(7, 32'hA00);
        chk("post_rst_pc",  {64'd0, issue_pc}, 96'hA00);
        chk("post_rst_imm", {64'd0, imm}, 96'h12345000);
        tick();
        chk("post_rst_occ", {93'd0, occupancy}, 96'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
